// File: rtl/dmem_if.sv
// Data-memory arbitration bus. It groups the CPU port, the debug/loader port,
// the RAM port and the conflict counter between the arbiter and its neighbours.
interface dmem_if;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;

    logic        dbg_req;
    logic        dbg_we;
    logic [31:0] dbg_addr;
    logic [31:0] dbg_wdata;
    logic        dbg_gnt;
    logic [31:0] dbg_rdata;
    logic        dbg_rvalid;

    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [15:0] conflict_cnt;

    // Arbiter side of the bus
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  mem_rdata,
        output cpu_rdata, cpu_stall,
        output dbg_gnt, dbg_rdata, dbg_rvalid,
        output mem_we, mem_addr, mem_wdata,
        output conflict_cnt
    );

    // Requester / memory side of the bus
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output mem_rdata,
        input  cpu_rdata, cpu_stall,
        input  dbg_gnt, dbg_rdata, dbg_rvalid,
        input  mem_we, mem_addr, mem_wdata,
        input  conflict_cnt
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter. The debug/loader port wins a conflict with
// the CPU unless the CPU has already been stalled STARVE_LIMIT consecutive
// cycles, in which case the CPU wins once and the debug request stays pending.
// The grant is combinational; the debug read data returns one cycle later.
module dmem_arbiter #(
    parameter logic [3:0] STARVE_LIMIT = 4'd3
) (
    input  logic   clk,
    input  logic   reset,
    dmem_if.slave  bus
);

    logic        cpu_gnt_s;
    logic        dbg_gnt_s;
    logic        cpu_stall_s;
    logic        both_req_s;
    logic [3:0]  stall_cnt_r;
    logic [15:0] conflict_cnt_r;
    logic        dbg_rvalid_r;
    logic [31:0] dbg_rdata_r;

    assign both_req_s = bus.cpu_req & bus.dbg_req;

    // Per-cycle ownership decision; reset forces no owner at all
    always_comb begin
        cpu_gnt_s = 1'b0;
        dbg_gnt_s = 1'b0;
        if (!reset) begin
            cpu_gnt_s = 1'b0;
            dbg_gnt_s = 1'b0;
        end else if (both_req_s) begin
            // A counter at (or somehow beyond) the limit always hands the slot to the CPU
            if (stall_cnt_r >= STARVE_LIMIT) begin
                cpu_gnt_s = 1'b1;
            end else begin
                dbg_gnt_s = 1'b1;
            end
        end else if (bus.cpu_req) begin
            cpu_gnt_s = 1'b1;
        end else if (bus.dbg_req) begin
            dbg_gnt_s = 1'b1;
        end else begin
            cpu_gnt_s = 1'b0;
            dbg_gnt_s = 1'b0;
        end
    end

    assign cpu_stall_s = reset & bus.cpu_req & ~cpu_gnt_s;

    // Route the owner's access onto the RAM port; idle bus is driven to zero
    always_comb begin
        bus.mem_we    = 1'b0;
        bus.mem_addr  = 32'h0000_0000;
        bus.mem_wdata = 32'h0000_0000;
        bus.cpu_rdata = 32'h0000_0000;
        case ({cpu_gnt_s, dbg_gnt_s})
            2'b10: begin
                bus.mem_we    = bus.cpu_we;
                bus.mem_addr  = bus.cpu_addr;
                bus.mem_wdata = bus.cpu_wdata;
                bus.cpu_rdata = bus.mem_rdata;
            end
            2'b01: begin
                bus.mem_we    = bus.dbg_we;
                bus.mem_addr  = bus.dbg_addr;
                bus.mem_wdata = bus.dbg_wdata;
            end
            default: begin
                bus.mem_we    = 1'b0;
                bus.mem_addr  = 32'h0000_0000;
                bus.mem_wdata = 32'h0000_0000;
                bus.cpu_rdata = 32'h0000_0000;
            end
        endcase
    end

    // Consecutive CPU stall cycles; any cycle the CPU is not stalled restarts the count
    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt_r <= 4'd0;
        end else if (cpu_stall_s) begin
            stall_cnt_r <= stall_cnt_r + 4'd1;
        end else begin
            stall_cnt_r <= 4'd0;
        end
    end

    // Saturating count of cycles in which both ports requested
    always_ff @(posedge clk) begin
        if (!reset) begin
            conflict_cnt_r <= 16'h0000;
        end else if (both_req_s && (conflict_cnt_r != 16'hFFFF)) begin
            conflict_cnt_r <= conflict_cnt_r + 16'h0001;
        end else begin
            conflict_cnt_r <= conflict_cnt_r;
        end
    end

    // Capture RAM data at the edge of a granted debug read; data holds otherwise
    always_ff @(posedge clk) begin
        if (!reset) begin
            dbg_rvalid_r <= 1'b0;
            dbg_rdata_r  <= 32'h0000_0000;
        end else if (dbg_gnt_s && !bus.dbg_we) begin
            dbg_rvalid_r <= 1'b1;
            dbg_rdata_r  <= bus.mem_rdata;
        end else begin
            dbg_rvalid_r <= 1'b0;
            dbg_rdata_r  <= dbg_rdata_r;
        end
    end

    assign bus.cpu_stall    = cpu_stall_s;
    assign bus.dbg_gnt      = dbg_gnt_s;
    assign bus.dbg_rvalid   = dbg_rvalid_r;
    assign bus.dbg_rdata    = dbg_rdata_r;
    assign bus.conflict_cnt = conflict_cnt_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a small RAM next to the arbiter, directed scenarios
// and random traffic, all scored against a behavioural model of the
// arbitration rules (stall run length, conflict tally, shadow memory).
module tb_dmem_arbiter;

    localparam int LIMIT = 3;

    logic clk;
    logic reset;
    dmem_if bus ();

    dmem_arbiter #(.STARVE_LIMIT(4'd3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Environment RAM: combinational read, write on rising edge
    logic [31:0] ram [0:255] = '{default: 32'h0};
    assign bus.mem_rdata = ram[bus.mem_addr[9:2]];

    // RAM write port
    always @(posedge clk) begin
        if (bus.mem_we) ram[bus.mem_addr[9:2]] <= bus.mem_wdata;
    end

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int          m_stalls = 0;
    int          m_conf   = 0;
    logic        m_rvalid = 1'b0;
    logic [31:0] m_rdata  = 32'h0;
    logic [31:0] ref_mem [0:255] = '{default: 32'h0};

    int          last_owner;      // 0 none, 1 cpu, 2 debug
    logic [31:0] last_cpu_rdata;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic run_cycle(input logic rn, input logic cr, input logic cw,
                             input logic [31:0] ca, input logic [31:0] cd,
                             input logic dr, input logic dw,
                             input logic [31:0] da, input logic [31:0] dd);
        int          owner;
        logic        e_stall;
        logic        e_we;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [31:0] e_crd;
        @(negedge clk);
        reset         = rn;
        bus.cpu_req   = cr;
        bus.cpu_we    = cw;
        bus.cpu_addr  = ca;
        bus.cpu_wdata = cd;
        bus.dbg_req   = dr;
        bus.dbg_we    = dw;
        bus.dbg_addr  = da;
        bus.dbg_wdata = dd;
        #1;
        // Who owns the RAM this cycle, from the rules
        if (!rn)               owner = 0;
        else if (cr && dr)     owner = (m_stalls < LIMIT) ? 2 : 1;
        else if (cr)           owner = 1;
        else if (dr)           owner = 2;
        else                   owner = 0;
        e_stall = rn && cr && (owner != 1);
        e_we    = (owner == 1) ? cw : (owner == 2) ? dw : 1'b0;
        e_addr  = (owner == 1) ? ca : (owner == 2) ? da : 32'h0;
        e_wdata = (owner == 1) ? cd : (owner == 2) ? dd : 32'h0;
        e_crd   = (owner == 1) ? ref_mem[ca[9:2]] : 32'h0;
        check_eq("cpu_stall", 32'(bus.cpu_stall), 32'(e_stall));
        check_eq("dbg_gnt",   32'(bus.dbg_gnt),   32'(owner == 2));
        check_eq("mem_we",    32'(bus.mem_we),    32'(e_we));
        check_eq("mem_addr",  bus.mem_addr,       e_addr);
        check_eq("mem_wdata", bus.mem_wdata,      e_wdata);
        check_eq("cpu_rdata", bus.cpu_rdata,      e_crd);
        last_owner     = owner;
        last_cpu_rdata = bus.cpu_rdata;
        @(posedge clk);
        if (!rn) begin
            m_stalls = 0;
            m_conf   = 0;
            m_rvalid = 1'b0;
            m_rdata  = 32'h0;
        end else begin
            m_stalls = e_stall ? m_stalls + 1 : 0;
            if (cr && dr) m_conf = (m_conf < 65535) ? m_conf + 1 : 65535;
            if (owner == 2 && !dw) begin
                m_rvalid = 1'b1;
                m_rdata  = ref_mem[da[9:2]];
            end else begin
                m_rvalid = 1'b0;
            end
            if (owner == 1 && cw) ref_mem[ca[9:2]] = cd;
            if (owner == 2 && dw) ref_mem[da[9:2]] = dd;
        end
        #1;
        check_eq("dbg_rvalid",   32'(bus.dbg_rvalid),   32'(m_rvalid));
        check_eq("dbg_rdata",    bus.dbg_rdata,         m_rdata);
        check_eq("conflict_cnt", 32'(bus.conflict_cnt), 32'(m_conf));
    endtask

    int exp_pat [0:7] = '{2, 2, 2, 1, 2, 2, 2, 1};

    initial begin
        reset         = 1'b0;
        bus.cpu_req   = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = 32'h0;
        bus.cpu_wdata = 32'h0;
        bus.dbg_req   = 1'b0;
        bus.dbg_we    = 1'b0;
        bus.dbg_addr  = 32'h0;
        bus.dbg_wdata = 32'h0;

        // Reset held with requests present: nothing may be granted
        run_cycle(1'b0, 1'b1, 1'b1, 32'h40, 32'h1, 1'b1, 1'b1, 32'h44, 32'h2);
        run_cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

        // Idle bus
        for (int i = 0; i < 3; i++)
            run_cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

        // CPU write then CPU read of 0x10
        run_cycle(1'b1, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0, 32'h0);
        run_cycle(1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        check_eq("cpu_read_0x10", last_cpu_rdata, 32'hDEADBEEF);

        // Debug loads 0x20, then reads it back with one-cycle latency
        run_cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h20, 32'h12345678);
        check_eq("dbg_write_no_rvalid", 32'(bus.dbg_rvalid), 32'h0);
        run_cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0);
        check_eq("dbg_read_rvalid", 32'(bus.dbg_rvalid), 32'h1);
        check_eq("dbg_read_0x20", bus.dbg_rdata, 32'h12345678);
        // Back-to-back debug reads, each with its own pulse
        run_cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h10, 32'h0);
        check_eq("dbg_b2b_0x10", bus.dbg_rdata, 32'hDEADBEEF);

        // Eight cycles of conflict from a clean reset
        run_cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 8; i++) begin
            run_cycle(1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0);
            check_eq("starve_pattern", 32'(last_owner), 32'(exp_pat[i]));
        end
        check_eq("conflict_8", 32'(bus.conflict_cnt), 32'h8);

        // Reset arriving right after a granted debug read drops the pending data
        run_cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0);
        run_cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0);
        check_eq("rst_rvalid", 32'(bus.dbg_rvalid), 32'h0);
        check_eq("rst_conflict", 32'(bus.conflict_cnt), 32'h0);

        // Random traffic with occasional resets
        for (int i = 0; i < 2000; i++) begin
            run_cycle(1'($urandom_range(0, 39) != 0),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      {22'h0, 8'($urandom_range(0, 255)), 2'b00}, $urandom,
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      {22'h0, 8'($urandom_range(0, 255)), 2'b00}, $urandom);
        end

        // Drive the conflict counter into saturation
        run_cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 65540; i++)
            run_cycle(1'b1, 1'b1, 1'b0, 32'h8, 32'h0, 1'b1, 1'b0, 32'hC, 32'h0);
        check_eq("conflict_sat", 32'(bus.conflict_cnt), 32'h0000FFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
